// File: rtl/param_seq_multiplier.sv
// N-bit sequential shift-add multiplier with per-operand signedness.
// One multiply at a time, start/done handshake, zero-operand early exit.
module param_seq_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           startButton,
    input  logic [1:0]     mode,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           endOfMultiplication,
    output logic [2*N-1:0] product,
    output logic [1:0]     current_state
);

    localparam int CW = $clog2(N + 1);
    localparam int AW = 2 * N + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N:0]    a_ext;
    logic [N:0]    b_ext;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    logic [N:0]    a_in;
    logic [N:0]    b_in;
    logic [AW-1:0] a_wide;
    logic [AW-1:0] addend;
    logic [N:0]    b_sh;
    logic          last;
    logic [AW-1:0] acc_next;

    // Operand extension by mode and the add/subtract for the current step
    always_comb begin
        a_in     = {(mode != 2'b00) & multiplicand[N-1], multiplicand};
        b_in     = {mode[0] & multiplier[N-1], multiplier};
        a_wide   = {{(N + 1){a_ext[N]}}, a_ext};
        addend   = a_wide << cnt;
        b_sh     = b_ext >> cnt;
        last     = (cnt == CW'(N));
        acc_next = acc;
        if (b_sh[0]) begin
            if (last) acc_next = acc - addend;
            else      acc_next = acc + addend;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_ext   <= '0;
            b_ext   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (startButton) begin
                        a_ext <= a_in;
                        b_ext <= b_in;
                        if (multiplicand == '0 || multiplier == '0) begin
                            product <= '0;
                            state   <= DONE;
                        end else begin
                            acc   <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        product <= acc_next[2*N-1:0];
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        busy                = (state != IDLE);
        endOfMultiplication = (state == DONE);
        current_state       = state;
    end

endmodule
